// File: rtl/reservoir_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// reservoir_sched_pkg
// Shared definitions for the reservoir scheduler:
//   - sched_state_t   : sequencer state encoding
//   - STATE_ADDR_BASE : first state-memory address written by a sequence
//   - STATE_ADDR_STEP : state-memory address increment per written node
// -----------------------------------------------------------------------------
package reservoir_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CALC  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WRITE = 3'd5
  } sched_state_t;

  localparam int unsigned STATE_ADDR_BASE = 0;
  localparam int unsigned STATE_ADDR_STEP = 1;

endpackage

// File: rtl/reservoir_scheduler_input_mask_mult.sv
// -----------------------------------------------------------------------------
// input_mask_mult
// Registered unsigned sample x mask multiply. The full-width product is
// shifted right by MASK_FRAC_BITS and truncated to DATA_WIDTH bits. The
// result register loads only while en is high and otherwise holds.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (result clears to 0)
//   en       : load strobe
//   sample   : DATA_WIDTH unsigned sample
//   mask     : MASK_WIDTH unsigned fixed-point mask
//   result   : DATA_WIDTH registered masked sample
// -----------------------------------------------------------------------------
module input_mask_mult #(
  parameter int DATA_WIDTH     = 32,
  parameter int MASK_WIDTH     = 16,
  parameter int MASK_FRAC_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [MASK_WIDTH-1:0] mask,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int PROD_WIDTH = DATA_WIDTH + MASK_WIDTH;

  logic [PROD_WIDTH-1:0] product_s;

  // Full-width unsigned product so no high bits are lost before the shift.
  always_comb begin
    product_s = PROD_WIDTH'(sample) * PROD_WIDTH'(mask);
  end

  // Result register: shift out the mask fraction, keep the low DATA_WIDTH bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= {DATA_WIDTH{1'b0}};
    end else if (en) begin
      result <= DATA_WIDTH'(product_s >> MASK_FRAC_BITS);
    end else begin
      result <= result;
    end
  end

endmodule

// File: rtl/reservoir_scheduler.sv
// -----------------------------------------------------------------------------
// reservoir_scheduler
// Sequences the time-multiplexed reservoir for one input sequence. For each
// sample and each virtual node it fetches sample and mask, forms the masked
// input, pulses the reservoir enable, waits for reservoir valid (never in
// the first WAIT cycle, since valid is combinational in the reservoir) and
// writes the reservoir output to the state memory.
// Optional feature macro: RESERVOIR_SCHED_TIMEOUT_EN adds a WAIT watchdog
// and the sticky timeout output.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start/num_samples : sequence request and sample count (latched on start)
//   sample_addr/data  : sample memory read port (1-cycle latency)
//   mask_addr/data    : mask memory read port (1-cycle latency)
//   res_en/res_din    : reservoir enable pulse and masked input
//   res_valid/res_dout: reservoir valid and output
//   state_wr_*        : state memory write port
//   busy, done        : sequence in progress, end-of-sequence pulse
//   timeout           : sticky watchdog flag (macro builds only)
// -----------------------------------------------------------------------------
module reservoir_scheduler
  import reservoir_sched_pkg::*;
#(
  parameter int VIRTUAL_NODES     = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int MASK_WIDTH        = 16,
  parameter int MASK_FRAC_BITS    = 8,
  parameter int SAMPLE_ADDR_WIDTH = 16,
  parameter int STATE_ADDR_WIDTH  = 24,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [SAMPLE_ADDR_WIDTH-1:0]       num_samples,
  output logic [SAMPLE_ADDR_WIDTH-1:0]       sample_addr,
  input  logic [DATA_WIDTH-1:0]              sample_data,
  output logic [$clog2(VIRTUAL_NODES)-1:0]   mask_addr,
  input  logic [MASK_WIDTH-1:0]              mask_data,
  output logic                               res_en,
  output logic [DATA_WIDTH-1:0]              res_din,
  input  logic                               res_valid,
  input  logic [DATA_WIDTH-1:0]              res_dout,
  output logic                               state_wr_en,
  output logic [STATE_ADDR_WIDTH-1:0]        state_wr_addr,
  output logic [DATA_WIDTH-1:0]              state_wr_data,
  output logic                               busy,
  output logic                               done
`ifdef RESERVOIR_SCHED_TIMEOUT_EN
  ,
  output logic                               timeout
`endif
);

  localparam int MASK_ADDR_WIDTH = $clog2(VIRTUAL_NODES);

  sched_state_t                 state_r;
  sched_state_t                 state_nxt_s;
  logic [SAMPLE_ADDR_WIDTH-1:0] num_r;
  logic                         first_wait_r;

  logic start_ok_s;
  logic last_node_s;
  logic last_sample_s;
  logic accept_s;
  logic timeout_hit_s;
  logic mult_en_s;
  logic res_en_nxt_s;
  logic wr_en_nxt_s;
  logic done_nxt_s;

`ifdef RESERVOIR_SCHED_TIMEOUT_EN
  logic [31:0] wait_cnt_r;
`endif

  // Sample and node counters double as the registered memory addresses.
  always_comb begin
    start_ok_s    = (state_r == ST_IDLE) && start;
    last_node_s   = (mask_addr == MASK_ADDR_WIDTH'(VIRTUAL_NODES - 1));
    last_sample_s = (sample_addr == (num_r - SAMPLE_ADDR_WIDTH'(1)));
    // first_wait_r masks the combinational valid seen right after ISSUE.
    accept_s      = (state_r == ST_WAIT) && !first_wait_r && res_valid;
`ifdef RESERVOIR_SCHED_TIMEOUT_EN
    timeout_hit_s = (state_r == ST_WAIT) && !accept_s &&
                    (wait_cnt_r == 32'(TIMEOUT_CYCLES - 1));
`else
    timeout_hit_s = 1'b0;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (num_samples != {SAMPLE_ADDR_WIDTH{1'b0}})) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: state_nxt_s = ST_CALC;
      ST_CALC:  state_nxt_s = ST_ISSUE;
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (accept_s) begin
          state_nxt_s = ST_WRITE;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (last_node_s && last_sample_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered control outputs.
  always_comb begin
    mult_en_s    = (state_r == ST_CALC);
    res_en_nxt_s = (state_r == ST_CALC);
    wr_en_nxt_s  = accept_s;
    done_nxt_s   = (start_ok_s && (num_samples == {SAMPLE_ADDR_WIDTH{1'b0}})) ||
                   ((state_r == ST_WRITE) && last_node_s && last_sample_s) ||
                   timeout_hit_s;
  end

  // Registered outputs, counters and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_en        <= 1'b0;
      state_wr_en   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      num_r         <= {SAMPLE_ADDR_WIDTH{1'b0}};
      first_wait_r  <= 1'b0;
      sample_addr   <= {SAMPLE_ADDR_WIDTH{1'b0}};
      mask_addr     <= {MASK_ADDR_WIDTH{1'b0}};
      state_wr_addr <= {STATE_ADDR_WIDTH{1'b0}};
      state_wr_data <= {DATA_WIDTH{1'b0}};
    end else begin
      res_en       <= res_en_nxt_s;
      state_wr_en  <= wr_en_nxt_s;
      busy         <= (state_nxt_s != ST_IDLE);
      done         <= done_nxt_s;
      first_wait_r <= (state_r == ST_ISSUE);
      if (start_ok_s) begin
        num_r         <= num_samples;
        sample_addr   <= {SAMPLE_ADDR_WIDTH{1'b0}};
        mask_addr     <= {MASK_ADDR_WIDTH{1'b0}};
        state_wr_addr <= STATE_ADDR_WIDTH'(STATE_ADDR_BASE);
      end else if (state_r == ST_WRITE) begin
        state_wr_addr <= state_wr_addr + STATE_ADDR_WIDTH'(STATE_ADDR_STEP);
        if (!last_node_s) begin
          mask_addr <= mask_addr + MASK_ADDR_WIDTH'(1);
        end else if (!last_sample_s) begin
          mask_addr   <= {MASK_ADDR_WIDTH{1'b0}};
          sample_addr <= sample_addr + SAMPLE_ADDR_WIDTH'(1);
        end else begin
          mask_addr <= mask_addr;
        end
      end else begin
        state_wr_addr <= state_wr_addr;
      end
      if (accept_s) begin
        state_wr_data <= res_dout;
      end else begin
        state_wr_data <= state_wr_data;
      end
    end
  end

`ifdef RESERVOIR_SCHED_TIMEOUT_EN
  // WAIT watchdog: counts WAIT cycles, flag stays set until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 32'd0;
      timeout    <= 1'b0;
    end else begin
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + 32'd1;
      end else begin
        wait_cnt_r <= 32'd0;
      end
      if (start_ok_s) begin
        timeout <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout <= 1'b1;
      end else begin
        timeout <= timeout;
      end
    end
  end
`endif

  input_mask_mult #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MASK_WIDTH    (MASK_WIDTH),
    .MASK_FRAC_BITS(MASK_FRAC_BITS)
  ) u_mult (
    .clk   (clk),
    .rst   (rst),
    .en    (mult_en_s),
    .sample(sample_data),
    .mask  (mask_data),
    .result(res_din)
  );

endmodule

// File: doc/reservoir_scheduler.md
# reservoir_scheduler

Sequences the time-multiplexed reservoir datapath for one input sequence. For each input sample it walks all virtual nodes and forms the masked input `sample × mask[v]`. It drives the one-cycle reservoir enable and waits for the reservoir-valid handshake. It then writes each resulting node state into the reservoir state memory used by the readout stage. It sits between the sample/mask memories and the reservoir ASIC wrapper.

## Interface
Parameters:
- `VIRTUAL_NODES`, 10: nodes per input sample.
- `DATA_WIDTH`, 32: sample, reservoir din/dout and state width.
- `MASK_WIDTH`, 16: unsigned mask word width.
- `MASK_FRAC_BITS`, 8: fractional bits of the mask.
- `SAMPLE_ADDR_WIDTH`, 16: sample memory address width.
- `STATE_ADDR_WIDTH`, 24: state memory address width.
- `TIMEOUT_CYCLES`, 65535: watchdog limit. Used only with the macro.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a sequence. Ignored while `busy`.
- `num_samples` in SAMPLE_ADDR_WIDTH: sample count, sampled at `start`.
- `sample_addr` out SAMPLE_ADDR_WIDTH: sample memory read address.
- `sample_data` in DATA_WIDTH: sample memory data, 1-cycle read latency.
- `mask_addr` out $clog2(VIRTUAL_NODES): mask memory address.
- `mask_data` in MASK_WIDTH: mask memory data, 1-cycle read latency.
- `res_en` out 1: reservoir enable pulse.
- `res_din` out DATA_WIDTH: masked input to the reservoir.
- `res_valid` in 1: reservoir idle / output valid.
- `res_dout` in DATA_WIDTH: reservoir output.
- `state_wr_en` out 1: state memory write strobe.
- `state_wr_addr` out STATE_ADDR_WIDTH: state memory write address.
- `state_wr_data` out DATA_WIDTH: state memory write data.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse at sequence end.
- `timeout` out 1: sticky watchdog error. Present only with the macro.

## Operation
- States are IDLE, FETCH, CALC, ISSUE, WAIT, WRITE.
- IDLE:
  - `start`=1 latches `num_samples` and clears the counters `s`, `v` and `wa`.
  - If `num_samples`=0, pulse `done` and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH: drive `sample_addr=s` and `mask_addr=v`, then go to CALC.
- CALC:
  - Register `res_din = (sample_data * mask_data) >> MASK_FRAC_BITS`.
  - The product is full width (DATA_WIDTH+MASK_WIDTH), unsigned, truncated to the low DATA_WIDTH bits after the shift.
  - Go to ISSUE.
- ISSUE: `res_en`=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Ignore `res_valid` in the first WAIT cycle after ISSUE, because the reservoir's valid signal is combinational.
  - From the second cycle on, `res_valid`=1 captures `res_dout` into `state_wr_data` and moves to WRITE.
- WRITE:
  - `state_wr_en`=1 with `state_wr_addr=wa`, then `wa++`.
  - If `v<VIRTUAL_NODES-1`: `v++`, go to FETCH.
  - Else if `s<num_samples-1`: `v=0`, `s++`, go to FETCH.
  - Else pulse `done` and go to IDLE.
- `res_din` holds its value from CALC until the next CALC.
- `busy`=1 in every state except IDLE.
- `start` while `busy` is ignored, with no restart.
- `rst` mid-operation aborts immediately to IDLE with all outputs at reset values. No partial write completes.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- All outputs are registered.
- `start` sampled at edge 0: FETCH in cycle 1, CALC in cycle 2, `res_en` high in cycle 3.
- Per node cost is 4 cycles + W, where W is the number of WAIT cycles, with W≥2.
- `state_wr_en` rises the cycle after `res_valid` is seen.
- `done` is asserted in the cycle after the last WRITE, coincident with `busy` falling.
- With `num_samples`=0, `done` is asserted the cycle after `start`.
- `res_valid` that is already high in the first WAIT cycle is never accepted.

## Configuration
- Macro `RESERVOIR_SCHED_TIMEOUT_EN`:
  - WAIT counts its cycles.
  - When the count reaches TIMEOUT_CYCLES, `timeout` is set (sticky until `rst` or the next accepted `start`) and the FSM goes to IDLE with a `done` pulse and no write.
- Without the macro: no counter and no `timeout` port. WAIT waits indefinitely.

## Structure
- Package `reservoir_sched_pkg` holds:
  - the state enum `sched_state_t`;
  - the state memory address arithmetic helper constants.
- Sub-module `input_mask_mult` holds the registered, truncating mask multiply with its enable. It is natural to split this out for reuse in the readout path.

## Test plan
- Bench parameters are VIRTUAL_NODES=4 and a model reservoir whose valid returns 3 cycles after `res_en`.
- `num_samples`=2, samples {0x100, 0x200}, masks {0x0180, 0x0100, 0x0080, 0x0200}:
  - `res_din` = 0x180, 0x100, 0x80, 0x200, 0x300, 0x200, 0x100, 0x400;
  - 8 writes at addresses 0–7;
  - one `done` pulse.
- `num_samples`=0: `done` is asserted the cycle after `start`, with no `res_en` and no `state_wr_en`.
- `start` re-pulsed during WAIT: ignored; the write count stays at 4×`num_samples`.
- `rst` asserted in WAIT of node 2: all outputs are 0 next cycle; a fresh `start` restarts at address 0.
- Valid held high continuously by the model: still exactly one write per node, and never in the first WAIT cycle.
- With `RESERVOIR_SCHED_TIMEOUT_EN` and TIMEOUT_CYCLES=16, with the model never raising valid:
  - `timeout`=1 and `done` pulse 16 cycles into WAIT;
  - no write.
